// File: rtl/mul_ci_pipe.sv
// Pipelined multiply custom instruction with a 2*WIDTH accumulator.
// Operands are captured on issue, multiplied once, and retired in order PIPE enabled cycles later.
module mul_ci_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 3
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clken,
    input  logic             start,
    input  logic [2:0]       n,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int PW = 2 * WIDTH;
    localparam int XW = WIDTH + 1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULXUU = 3'd1,
        OP_MULXSS = 3'd2,
        OP_MULXSU = 3'd3,
        OP_MAC    = 3'd4,
        OP_MACCLR = 3'd5,
        OP_ACCHI  = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    logic                 cap_vld_d, cap_vld_q;
    op_e                  cap_op_d, cap_op_q;
    logic signed [XW-1:0] cap_a_d, cap_a_q;
    logic signed [XW-1:0] cap_b_d, cap_b_q;
    logic signed [PW-1:0] prod_c;

    logic                 ret_vld;
    op_e                  ret_op;
    logic        [PW-1:0] ret_prod;

    logic                 done_d, done_q;
    logic [WIDTH-1:0]     result_d, result_q;
    logic [PW-1:0]        acc_d, acc_q;

    // One extra operand bit lets a single signed multiplier cover every signedness mix.
    always_comb begin
        logic sign_a;
        logic sign_b;
        sign_a    = (n == OP_MULXSS) || (n == OP_MULXSU) || (n == OP_MAC) || (n == OP_MACCLR);
        sign_b    = (n == OP_MULXSS) || (n == OP_MAC) || (n == OP_MACCLR);
        cap_vld_d = start;
        cap_op_d  = op_e'(n);
        cap_a_d   = {sign_a & dataa[WIDTH-1], dataa};
        cap_b_d   = {sign_b & datab[WIDTH-1], datab};
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            cap_vld_q <= 1'b0;
            cap_op_q  <= OP_MUL;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
        end else if (clken) begin
            cap_vld_q <= cap_vld_d;
            cap_op_q  <= cap_op_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
        end
    end

    assign prod_c = PW'(cap_a_q) * PW'(cap_b_q);

    generate
        if (PIPE == 1) begin : g_no_stage
            assign ret_vld  = cap_vld_q;
            assign ret_op   = cap_op_q;
            assign ret_prod = prod_c;
            assign busy     = cap_vld_q;
        end else begin : g_stage
            logic          stg_vld_d  [PIPE-1];
            logic          stg_vld_q  [PIPE-1];
            op_e           stg_op_d   [PIPE-1];
            op_e           stg_op_q   [PIPE-1];
            logic [PW-1:0] stg_prod_d [PIPE-1];
            logic [PW-1:0] stg_prod_q [PIPE-1];
            logic          any_vld;

            always_comb begin
                stg_vld_d[0]  = cap_vld_q;
                stg_op_d[0]   = cap_op_q;
                stg_prod_d[0] = prod_c;
                for (int i = 1; i < PIPE - 1; i++) begin
                    stg_vld_d[i]  = stg_vld_q[i-1];
                    stg_op_d[i]   = stg_op_q[i-1];
                    stg_prod_d[i] = stg_prod_q[i-1];
                end
            end

            always_ff @(posedge clock) begin
                if (aclr) begin
                    for (int i = 0; i < PIPE - 1; i++) begin
                        stg_vld_q[i]  <= 1'b0;
                        stg_op_q[i]   <= OP_MUL;
                        stg_prod_q[i] <= '0;
                    end
                end else if (clken) begin
                    for (int i = 0; i < PIPE - 1; i++) begin
                        stg_vld_q[i]  <= stg_vld_d[i];
                        stg_op_q[i]   <= stg_op_d[i];
                        stg_prod_q[i] <= stg_prod_d[i];
                    end
                end
            end

            always_comb begin
                any_vld = cap_vld_q;
                for (int i = 0; i < PIPE - 1; i++) begin
                    any_vld = any_vld | stg_vld_q[i];
                end
            end

            assign ret_vld  = stg_vld_q[PIPE-2];
            assign ret_op   = stg_op_q[PIPE-2];
            assign ret_prod = stg_prod_q[PIPE-2];
            assign busy     = any_vld;
        end
    endgenerate

    // The accumulator only moves here, so ops retiring back-to-back see each other in order.
    always_comb begin
        done_d   = ret_vld;
        result_d = result_q;
        acc_d    = acc_q;
        if (ret_vld) begin
            case (ret_op)
                OP_MUL:    result_d = ret_prod[WIDTH-1:0];
                OP_MULXUU,
                OP_MULXSS,
                OP_MULXSU: result_d = ret_prod[PW-1:WIDTH];
                OP_MAC: begin
                    acc_d    = acc_q + ret_prod;
                    result_d = acc_d[WIDTH-1:0];
                end
                OP_MACCLR: begin
                    acc_d    = ret_prod;
                    result_d = acc_d[WIDTH-1:0];
                end
                OP_ACCHI:  result_d = acc_q[PW-1:WIDTH];
                default:   result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            done_q   <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
        end else if (clken) begin
            done_q   <= done_d;
            result_q <= result_d;
            acc_q    <= acc_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_ci_pipe.sv
// Self-checking bench for mul_ci_pipe: directed scenarios plus randomized traffic
// compared against a sequential reference model of the instruction set.
module tb_mul_ci_pipe;

    localparam int WIDTH = 32;
    localparam int PIPE  = 3;

    logic             clock = 1'b0;
    logic             aclr;
    logic             clken;
    logic             start;
    logic [2:0]       n;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mul_ci_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
        .clock (clock),
        .aclr  (aclr),
        .clken (clken),
        .start (start),
        .n     (n),
        .dataa (dataa),
        .datab (datab),
        .result(result),
        .done  (done),
        .busy  (busy)
    );

    // Reference model: every op is evaluated in issue order against a plain 64-bit accumulator,
    // and its answer is released PIPE enabled edges later.
    typedef struct {
        logic [31:0] res;
        int          due;
    } ent_t;

    ent_t        pend[$];
    logic [63:0] m_acc       = '0;
    int          en_cnt      = 0;
    logic        exp_done    = 1'b0;
    logic [31:0] exp_result  = '0;
    logic        exp_busy    = 1'b0;

    function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = ua * ub; return p[63:32]; end
            3'd2: begin p = sa * sb; return p[63:32]; end
            3'd3: begin p = sa * ub; return p[63:32]; end
            3'd4: begin p = sa * sb; m_acc = m_acc + p; return m_acc[31:0]; end
            3'd5: begin p = sa * sb; m_acc = p; return m_acc[31:0]; end
            3'd6: begin p = m_acc; return p[63:32]; end
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick(input logic r, input logic e, input logic s, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        ent_t ent;
        aclr  = r;
        clken = e;
        start = s;
        n     = op;
        dataa = a;
        datab = b;
        @(posedge clock);
        #1;
        if (r) begin
            pend.delete();
            m_acc      = '0;
            exp_done   = 1'b0;
            exp_result = '0;
        end else if (e) begin
            en_cnt++;
            exp_done = 1'b0;
            if (pend.size() > 0 && pend[0].due == en_cnt) begin
                exp_done   = 1'b1;
                exp_result = pend[0].res;
                void'(pend.pop_front());
            end
            if (s) begin
                ent.res = model_op(op, a, b);
                ent.due = en_cnt + PIPE;
                pend.push_back(ent);
            end
        end
        exp_busy = (pend.size() > 0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1, 3'd4, 32'd5, 32'd6);
        tick(1'b1, 1'b0, 1'b1, 3'd0, 32'd7, 32'd8);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result); end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_start_ignored: busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_defaults();
        tick(1'b0, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2);
        for (int i = 1; i <= PIPE; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL default_cycle%0d: busy=%b done=%b want 1/0", i, busy, done);
            end
            if (i < PIPE) tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL default_done: done=%b result=%h want 1/fffffffe", done, result);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL default_busy_end: got %b want 0", busy); end
        checks++;
        if (result !== exp_result) begin
            errors++;
            $display("[TB] FAIL default_model: got %h want %h", result, exp_result);
        end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b0 || result !== 32'hFFFF_FFFE) begin
            errors++;
            $display("[TB] FAIL default_pulse_end: done=%b result=%h want 0/fffffffe", done, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want_hi [2];
        logic [31:0] want_mac [3];
        want_hi[0]  = 32'h0000_0001;
        want_hi[1]  = 32'hFFFF_FFFF;
        want_mac[0] = 32'h0000_000C;
        want_mac[1] = 32'hFFFF_FFEE;
        want_mac[2] = 32'hFFFF_FFFF;

        tick(1'b0, 1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2);
        tick(1'b0, 1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < PIPE - 2; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
            checks++;
            if (done !== 1'b1 || result !== want_hi[i]) begin
                errors++;
                $display("[TB] FAIL b2b_hi%0d: done=%b result=%h want 1/%h", i, done, result, want_hi[i]);
            end
        end

        tick(1'b0, 1'b1, 1'b1, 3'd5, 32'd3, 32'd4);
        tick(1'b0, 1'b1, 1'b1, 3'd4, 32'hFFFF_FFFB, 32'd6);
        tick(1'b0, 1'b1, 1'b1, 3'd6, 32'd0, 32'd0);
        for (int i = 0; i < PIPE - 3; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
            checks++;
            if (done !== 1'b1 || result !== want_mac[i]) begin
                errors++;
                $display("[TB] FAIL b2b_mac%0d: done=%b result=%h want 1/%h", i, done, result, want_mac[i]);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_clken();
        tick(1'b0, 1'b1, 1'b1, 3'd0, 32'd7, 32'd9);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b1, 3'd1, 32'd1, 32'd1);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL clken_freeze%0d: done=%b busy=%b want 0/1", i, done, busy);
            end
        end
        for (int i = 1; i < PIPE; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL clken_early: done=%b want 0", done); end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'd63) begin
            errors++;
            $display("[TB] FAIL clken_done: done=%b result=%0d want 1/63", done, result);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b1, 3'd2, 32'd3, 32'd3);
            checks++;
            if (done !== 1'b1 || result !== 32'd63) begin
                errors++;
                $display("[TB] FAIL clken_hold%0d: done=%b result=%0d want 1/63", i, done, result);
            end
        end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clken_release: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_reset_inflight();
        tick(1'b0, 1'b1, 1'b1, 3'd4, 32'd10, 32'd10);
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        tick(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL flush_state: done=%b busy=%b result=%h want 0/0/0", done, busy, result);
        end
        for (int i = 0; i < PIPE + 1; i++) begin
            tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
            checks++;
            if (done !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_done%0d: done=%b want 0", i, done); end
        end
        tick(1'b0, 1'b1, 1'b1, 3'd6, 32'd0, 32'd0);
        for (int i = 0; i < PIPE; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL flush_acchi: done=%b result=%h want 1/0", done, result);
        end
    endtask

    task automatic test_reserved();
        tick(1'b0, 1'b1, 1'b1, 3'd5, 32'h1234_5678, 32'h0000_0100);
        tick(1'b0, 1'b1, 1'b1, 3'd7, 32'd5, 32'd5);
        tick(1'b0, 1'b1, 1'b1, 3'd6, 32'd0, 32'd0);
        for (int i = 0; i < PIPE - 2; i++) tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'h3456_7800) begin
            errors++;
            $display("[TB] FAIL rsvd_setup: done=%b result=%h want 1/34567800", done, result);
        end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL rsvd_result: done=%b result=%h want 1/0", done, result);
        end
        tick(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        checks++;
        if (done !== 1'b1 || result !== 32'h0000_0012) begin
            errors++;
            $display("[TB] FAIL rsvd_acchi: done=%b result=%h want 1/00000012", done, result);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4];
        logic [31:0] a, b;
        logic        r, e, s;
        logic [2:0]  op;
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            e  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 2) != 0);
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            tick(r, e, s, op, a, b);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("[TB] FAIL rand_done cycle %0d: got %b want %b", i, done, exp_done);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("[TB] FAIL rand_busy cycle %0d: got %b want %b", i, busy, exp_busy);
            end
            checks++;
            if (result !== exp_result) begin
                errors++;
                $display("[TB] FAIL rand_result cycle %0d: got %h want %h", i, result, exp_result);
            end
        end
    endtask

    initial begin
        aclr  = 1'b1;
        clken = 1'b0;
        start = 1'b0;
        n     = 3'd0;
        dataa = '0;
        datab = '0;
        test_reset();
        test_defaults();
        test_back_to_back();
        test_clken();
        test_reset_inflight();
        test_reserved();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_ci_pipe.md
Name: mul_ci_pipe

Overview:
Parametrised, fully pipelined multi-cycle Nios custom-instruction multiplier. It is the successor to the fixed 16x16 unsigned two-stage multiplier custom instruction. Width and pipeline depth are configurable, and the opcode `n` selects signed/unsigned high-word products plus a 2*WIDTH multiply-accumulate. The block sits on the CPU custom-instruction slave port and uses a start/done handshake, accepting one operation per enabled cycle.

Parameters:
WIDTH, 32, operand and result width in bits (8..32).
PIPE, 3, issue-to-done latency in enabled cycles (1..6).

Ports:
clock  in  1  system clock; all state updates on its rising edge.
aclr  in  1  reset, synchronous, active-high; sampled on the clock edge; overrides clken.
clken  in  1  pipeline enable; low freezes every register, including the accumulator.
start  in  1  issue strobe; sampled only when clken=1.
n  in  3  opcode, captured with start.
dataa  in  WIDTH  operand A, captured with start.
datab  in  WIDTH  operand B, captured with start.
result  out  WIDTH  result word, valid when done=1; holds its value otherwise.
done  out  1  one-cycle completion pulse, one per accepted start.
busy  out  1  high while any accepted operation has not yet retired.

Behaviour:
- Reset (aclr=1 at the edge):
  - All stage-valid bits, done, busy, result and the 2*WIDTH accumulator go to 0.
  - In-flight operations are dropped with no done.
  - A start in the same cycle as reset is ignored.
- Issue:
  - An operation is accepted when clken=1 and start=1. n, dataa and datab are captured in the same cycle.
  - A new start is legal in every enabled cycle; there is no backpressure.
- Latency:
  - Accepted at enabled edge k, done=1 and result valid after enabled edge k+PIPE.
  - Disabled cycles (clken=0) do not count toward latency.
- done:
  - High for exactly one cycle per operation, then 0.
  - If clken drops while done=1, done and result hold until the next enabled edge.
- Ordering: operations retire strictly in issue order, at most one per cycle.
- Opcodes (P = full 2*WIDTH product):
  - 0 MUL: P low WIDTH bits (identical signed/unsigned).
  - 1 MULXUU: high WIDTH bits of unsigned*unsigned.
  - 2 MULXSS: high WIDTH bits of signed*signed.
  - 3 MULXSU: high WIDTH bits of signed A * unsigned B.
  - 4 MAC: acc <= acc + signed P; result = new acc low WIDTH.
  - 5 MACCLR: acc <= signed P; result = new acc low WIDTH.
  - 6 ACCHI: no acc change; result = acc high WIDTH bits; same PIPE latency.
  - 7 reserved: result = 0, done still pulses, acc unchanged.
- Accumulator:
  - Updated only at the retirement stage, so back-to-back MAC/MACCLR/ACCHI see every earlier op's effect.
  - Arithmetic is modulo 2^(2*WIDTH) and wraps silently; no overflow flag.
- Product pipeline:
  - Operands are sign- or zero-extended to WIDTH+1 bits per opcode.
  - One (WIDTH+1)x(WIDTH+1) signed multiply, truncated to 2*WIDTH bits.
  - Product is registered across PIPE-1 stages, followed by a final result/acc stage.
  - PIPE=1 means result is registered directly from the combinational product.
- busy = OR of the stage-valid bits.

Test Plan:
- Defaults. n=0, A=0xFFFFFFFF, B=2 -> after 3 enabled edges: done=1 for one cycle, result=0xFFFFFFFE; busy=1 for cycles 1-3 then 0.
- Same operands back-to-back with n=1 then n=2 -> consecutive done pulses: result=0x00000001, then 0xFFFFFFFF (high word of -1*2).
- Back-to-back MACCLR(3,4), MAC(-5,6), ACCHI(0,0) -> results 0x0000000C, 0xFFFFFFEE, 0xFFFFFFFF on three consecutive done cycles.
- Issue MUL(7,9); drop clken for 2 cycles after the first edge -> done delayed by 2 cycles, result=63; no register changes while clken=0.
- MAC in flight, then aclr for 1 cycle -> no done, busy=0 and result=0 on the following cycle; subsequent ACCHI returns 0.
- n=7 with A=5, B=5 -> done pulses with result=0; a following ACCHI returns the unchanged accumulator.
